// File: rtl/inst_queue_if.sv
// Fetch/issue-side bundle of the instruction queue.
// Enqueue: slot-1 (and optionally slot-2) is taken at the posedge when w_ena1_i=1 and full_o=0.
// Dequeue: r_num_i entries are retired from the head, clipped to count_o. flush empties the queue.
interface inst_queue_if #(
  parameter int PTR_W = 3
);
  logic              flush;
  logic              w_ena1_i;
  logic              w_ena2_i;
  logic [31:0]       w_pc1_i;
  logic [31:0]       w_pc2_i;
  logic [31:0]       w_inst1_i;
  logic [31:0]       w_inst2_i;
  logic [2:0]        w_exc1_i;
  logic [2:0]        w_exc2_i;
  logic [1:0]        r_num_i;
  logic              full_o;
  logic              empty_o;
  logic [PTR_W:0]    count_o;
  logic              r_valid1_o;
  logic              r_valid2_o;
  logic [31:0]       r_pc1_o;
  logic [31:0]       r_pc2_o;
  logic [31:0]       r_inst1_o;
  logic [31:0]       r_inst2_o;
  logic [2:0]        r_exc1_o;
  logic [2:0]        r_exc2_o;

  modport master (
    output flush, w_ena1_i, w_ena2_i, w_pc1_i, w_pc2_i, w_inst1_i, w_inst2_i,
           w_exc1_i, w_exc2_i, r_num_i,
    input  full_o, empty_o, count_o, r_valid1_o, r_valid2_o, r_pc1_o, r_pc2_o,
           r_inst1_o, r_inst2_o, r_exc1_o, r_exc2_o
  );

  modport slave (
    input  flush, w_ena1_i, w_ena2_i, w_pc1_i, w_pc2_i, w_inst1_i, w_inst2_i,
           w_exc1_i, w_exc2_i, r_num_i,
    output full_o, empty_o, count_o, r_valid1_o, r_valid2_o, r_pc1_o, r_pc2_o,
           r_inst1_o, r_inst2_o, r_exc1_o, r_exc2_o
  );
endinterface

// File: rtl/inst_queue.sv
// Dual-issue instruction queue: circular buffer, two-wide enqueue, first-word-fall-through
// read of the two oldest entries.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic         clk,
  input logic         rst,
  inst_queue_if.slave q
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  exc;
  } entry_t;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [PTR_W:0]   count;
  logic [1:0]       enq;
  logic [1:0]       deq;
  logic             full;
  entry_t           ent1;
  entry_t           ent2;
  logic             valid1;
  logic             valid2;

  // Space freed by this cycle's dequeue is not offered to this cycle's enqueue.
  always_comb begin
    full    = (count >= FULL_CNT);
    enq     = 2'd0;
    if (!full && q.w_ena1_i) enq = q.w_ena2_i ? 2'd2 : 2'd1;
    deq     = ({{(PTR_W-1){1'b0}}, q.r_num_i} > count) ? count[1:0] : q.r_num_i;
    head_p1 = head + ONE_PTR;
    tail_p1 = tail + ONE_PTR;
  end

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq);
      tail  <= tail + PTR_W'(enq);
      count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    end
  end

  // Storage is never cleared; count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && !q.flush && enq != 2'd0) begin
      mem[tail] <= '{pc: q.w_pc1_i, inst: q.w_inst1_i, exc: q.w_exc1_i};
      if (enq == 2'd2) mem[tail_p1] <= '{pc: q.w_pc2_i, inst: q.w_inst2_i, exc: q.w_exc2_i};
    end
  end

  always_comb begin
    ent1         = mem[head];
    ent2         = mem[head_p1];
    valid1       = (count != '0);
    valid2       = (count > ONE_CNT);
    q.full_o     = full;
    q.empty_o    = (count == '0);
    q.count_o    = count;
    q.r_valid1_o = valid1;
    q.r_valid2_o = valid2;
    q.r_pc1_o    = valid1 ? ent1.pc   : 32'd0;
    q.r_inst1_o  = valid1 ? ent1.inst : 32'd0;
    q.r_exc1_o   = valid1 ? ent1.exc  : 3'd0;
    q.r_pc2_o    = valid2 ? ent2.pc   : 32'd0;
    q.r_inst2_o  = valid2 ? ent2.inst : 32'd0;
    q.r_exc2_o   = valid2 ? ent2.exc  : 3'd0;
  end
endmodule
